// File: rtl/cmos_bist_pkg.sv
// Shared types and constants for the CMOS gate BIST controller.
package cmos_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } bist_state_t;

  // Truth table of the L-gate: a = x[2] ? ~x[0] : x[1]
  localparam logic [7:0] L_GATE_TT = 8'h5C;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable settle down-counter; zero flags the sample point for the current vector.
module bist_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cmos_gate_bist_ctrl.sv
// Sweeps every input vector into a gate under test and compares the observed truth table.
// Define CMOS_BIST_FAIL_CAPTURE_EN to add the fail_idx (first mismatching vector) output.
module cmos_gate_bist_ctrl
  import cmos_bist_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [tt_width(N_IN)-1:0] EXPECTED_TT = L_GATE_TT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic [N_IN-1:0]           dut_x,
  input  logic                      dut_a,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [tt_width(N_IN)-1:0] obs_tt
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
  ,
  output logic [N_IN-1:0]           fail_idx
`endif
);

  localparam int TT_W = tt_width(N_IN);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

  bist_state_t     state;
  logic [N_IN-1:0] idx;
  logic            cnt_zero;
  logic            accept;
  logic            t_load;
  logic            t_clr;
  logic            t_dec;

  assign accept = (state == IDLE) && start && !abort;
  assign t_load = accept ||
                  ((state == SETTLE) && !abort && cnt_zero && (idx != LAST_IDX));
  assign t_clr  = ((state == SETTLE) && abort) || (state == CHECK);
  assign t_dec  = (state == SETTLE);

  bist_settle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .clr      (t_clr),
    .dec      (t_dec),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  // idx is itself a register, so it doubles as the registered gate drive.
  assign dut_x = idx;

`ifdef CMOS_BIST_FAIL_CAPTURE_EN
  logic fail_found;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      obs_tt <= '0;
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
      fail_idx   <= '0;
      fail_found <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= SETTLE;
            idx    <= '0;
            busy   <= 1'b1;
            pass   <= 1'b0;
            obs_tt <= '0;
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
            fail_idx   <= '0;
            fail_found <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else if (cnt_zero) begin
            obs_tt[idx] <= dut_a;
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
            if (!fail_found && (dut_a != EXPECTED_TT[idx])) begin
              fail_idx   <= idx;
              fail_found <= 1'b1;
            end
`endif
            if (idx == LAST_IDX) begin
              state <= CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        CHECK: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (obs_tt == EXPECTED_TT);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_gate_bist_ctrl.sv
// Directed bench for cmos_gate_bist_ctrl: default settle time plus a SETTLE_CYCLES=1 instance.
module tb_cmos_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [2:0] dut_x;
  logic       dut_a;
  logic       busy, done, pass;
  logic [7:0] obs_tt;

  logic       start_f, abort_f;
  logic [2:0] dut_x_f;
  logic       dut_a_f;
  logic       busy_f, done_f, pass_f;
  logic [7:0] obs_tt_f;

`ifdef CMOS_BIST_FAIL_CAPTURE_EN
  logic [2:0] fail_idx, fail_idx_f;
`endif

  int mode;  // 0 good gate, 1 stuck-at-0, 2 inverted
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic l_gate(input logic [2:0] x);
    return x[2] ? ~x[0] : x[1];
  endfunction

  assign dut_a   = (mode == 0) ? l_gate(dut_x) : (mode == 1) ? 1'b0 : ~l_gate(dut_x);
  assign dut_a_f = l_gate(dut_x_f);

  cmos_gate_bist_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .dut_x    (dut_x),
    .dut_a    (dut_a),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .obs_tt   (obs_tt)
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
    ,
    .fail_idx (fail_idx)
`endif
  );

  cmos_gate_bist_ctrl #(
    .SETTLE_CYCLES (1)
  ) u_fast (
    .clk      (clk),
    .rst      (rst),
    .start    (start_f),
    .abort    (abort_f),
    .dut_x    (dut_x_f),
    .dut_a    (dut_a_f),
    .busy     (busy_f),
    .done     (done_f),
    .pass     (pass_f),
    .obs_tt   (obs_tt_f)
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
    ,
    .fail_idx (fail_idx_f)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),   0);
    chk({tag, "_done"},   32'(done),   0);
    chk({tag, "_pass"},   32'(pass),   0);
    chk({tag, "_obs_tt"}, 32'(obs_tt), 0);
    chk({tag, "_dut_x"},  32'(dut_x),  0);
  endtask

  // Full sweep on u_dut with fixed timing: accept edge 0, done visible after edge 17.
  task automatic sweep(input string tag, input logic [7:0] exp_tt, input logic exp_pass,
                       input logic [2:0] exp_fidx);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      chk({tag, "_busy"},  32'(busy), 1);
      chk({tag, "_early_done"}, 32'(done), 0);
      chk({tag, "_dut_x"}, 32'(dut_x), (k < 16) ? k / 2 : 7);
      @(negedge clk);
    end
    chk({tag, "_done"},     32'(done),   1);
    chk({tag, "_busy_end"}, 32'(busy),   0);
    chk({tag, "_pass"},     32'(pass),   32'(exp_pass));
    chk({tag, "_obs_tt"},   32'(obs_tt), 32'(exp_tt));
    chk({tag, "_x_idle"},   32'(dut_x),  0);
`ifdef CMOS_BIST_FAIL_CAPTURE_EN
    chk({tag, "_fail_idx"}, 32'(fail_idx), 32'(exp_fidx));
`else
    if (exp_fidx != 3'd0) n_vec = n_vec + 0;
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done),   0);
    chk({tag, "_pass_hold"},  32'(pass),   32'(exp_pass));
    chk({tag, "_obs_hold"},   32'(obs_tt), 32'(exp_tt));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_f = 1'b0; abort_f = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    chk("reset_busy_f", 32'(busy_f), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1-3: good gate, stuck-at-0, inverted
    mode = 0; sweep("good", 8'h5C, 1'b1, 3'd0);
    mode = 1; sweep("stuck0", 8'h00, 1'b0, 3'd2);
    mode = 2; sweep("invert", 8'hA3, 1'b0, 3'd0);

    // 4: abort after edge 6 with start held high; captures of x=0,1 (inverted gate) remain
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk("abort_run_x", 32'(dut_x), k / 2);
      chk("abort_run_busy", 32'(busy), 1);
      if (k == 5) abort = 1'b1;
      @(negedge clk);
    end
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_x",    32'(dut_x), 0);
    chk("abort_obs",  32'(obs_tt), 32'h03);
    @(negedge clk);
    chk("abort_wins_start", 32'(busy), 0);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end

    // 5: reset mid-sweep at dut_x=3, then a clean sweep
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_x", 32'(dut_x), 3);
    rst = 1'b1;
    #1;
    chk_idle_zero("rst_mid");
    @(negedge clk);
    chk("rst_no_done", 32'(done), 0);
    rst = 1'b0;
    sweep("post_rst", 8'h5C, 1'b1, 3'd0);

    // 6: SETTLE_CYCLES=1, start held: done every 10 cycles
    @(negedge clk); start_f = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if ((c % 10) == 9) begin
        chk("fast_done",   32'(done_f),   1);
        chk("fast_pass",   32'(pass_f),   1);
        chk("fast_obs",    32'(obs_tt_f), 32'h5C);
        chk("fast_busy_end", 32'(busy_f), 0);
      end else begin
        chk("fast_busy",  32'(busy_f), 1);
        chk("fast_nodone", 32'(done_f), 0);
        chk("fast_x",     32'(dut_x_f), ((c % 10) < 8) ? (c % 10) : 7);
      end
      @(negedge clk);
    end
    start_f = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
